xera4_video_scan: RTL and testbench

XERA4_VIDEO_SCAN -- requirements
Module: xera4_video_scan

---
 rtl/xera4_video_scan.sv | 104 ++++++++++
 tb/tb_xera4_video_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/xera4_video_scan.sv
// Raster scan generator: 160x120 byte framebuffer doubled to 320x240, RRRGGGBB pixels.
// Rd_Add tracks the counters with zero lag; every other output is registered two clocks behind the counters, matching the memory read latency.
module xera4_video_scan #(
    parameter int          H_ACTIVE = 320,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 32,
    parameter int          H_BP     = 32,
    parameter int          V_ACTIVE = 240,
    parameter int          V_FP     = 3,
    parameter int          V_SYNC   = 4,
    parameter int          V_BP     = 15,
    parameter logic [14:0] BASE     = 15'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] Rd_Add,
    input  logic [7:0]  Rd_In,
    output logic [7:0]  RGB,
    output logic        DE,
    output logic        HSync_n,
    output logic        VSync_n,
    output logic        MI
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [8:0]  HA     = 9'(H_ACTIVE);
    localparam logic [8:0]  HS_BEG = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0]  HS_END = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0]  HL     = 9'(H_TOTAL - 1);
    localparam logic [8:0]  VA     = 9'(V_ACTIVE);
    localparam logic [8:0]  VS_BEG = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0]  VS_END = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0]  VL     = 9'(V_TOTAL - 1);
    localparam logic [14:0] STRIDE = 15'd160;

    logic [8:0]  hc, vc, hc_nx, vc_nx;
    logic [14:0] line_base, line_base_nx, add_nx;
    logic        act0, hs0, vs0, mi0;
    logic        act_d1, hs_d1, vs_d1, mi_d1;

    always_comb begin
        act0         = (hc < HA) && (vc < VA);
        hs0          = !((hc >= HS_BEG) && (hc < HS_END));
        vs0          = !((vc >= VS_BEG) && (vc < VS_END));
        mi0          = (vc == VA);
        hc_nx        = hc + 9'd1;
        vc_nx        = vc;
        line_base_nx = line_base;
        add_nx       = Rd_Add;
        if (hc == HL) begin
            hc_nx = '0;
            if (vc == VL) begin
                vc_nx        = '0;
                line_base_nx = BASE;
                add_nx       = BASE;
            end else begin
                vc_nx = vc + 9'd1;
                // Each byte row covers two scan lines, so the row base moves on after odd lines.
                if ((vc < VA) && vc[0])
                    line_base_nx = line_base + STRIDE;
                if (vc_nx < VA)
                    add_nx = line_base_nx;
            end
        end else if (hc[0] && (hc_nx < HA) && (vc < VA)) begin
            add_nx = Rd_Add + 15'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc        <= '0;
            vc        <= '0;
            line_base <= BASE;
            Rd_Add    <= BASE;
            act_d1    <= 1'b0;
            hs_d1     <= 1'b1;
            vs_d1     <= 1'b1;
            mi_d1     <= 1'b0;
            RGB       <= 8'h00;
            DE        <= 1'b0;
            HSync_n   <= 1'b1;
            VSync_n   <= 1'b1;
            MI        <= 1'b0;
        end else begin
            hc        <= hc_nx;
            vc        <= vc_nx;
            line_base <= line_base_nx;
            Rd_Add    <= add_nx;
            act_d1    <= act0;
            hs_d1     <= hs0;
            vs_d1     <= vs0;
            mi_d1     <= mi0;
            // Rd_In answers the address issued one clock earlier, lining up with act_d1.
            RGB       <= act_d1 ? Rd_In : 8'h00;
            DE        <= act_d1;
            HSync_n   <= hs_d1;
            VSync_n   <= vs_d1;
            MI        <= mi_d1;
        end
    end

endmodule

// File: tb/tb_xera4_video_scan.sv
// Directed bench for xera4_video_scan with a 26-line frame (16 active lines) so whole frames fit the run.
// Second instance uses BASE=7FF0 to exercise the 15-bit address wrap.
module tb_xera4_video_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] add0, add1;
    logic [7:0]  rd0 = 8'h00, rd1 = 8'h00;
    logic [7:0]  rgb0, rgb1;
    logic        de0, hs0, vs0, mi0;
    logic        de1, hs1, vs1, mi1;

    always #5 clk = ~clk;

    // Registered memory model: data is the low byte of the address.
    always @(posedge clk) begin
        rd0 <= add0[7:0];
        rd1 <= add1[7:0];
    end

    xera4_video_scan #(.V_ACTIVE(16), .V_FP(3), .V_SYNC(4), .V_BP(3)) u0 (
        .clk(clk), .rst(rst), .Rd_Add(add0), .Rd_In(rd0), .RGB(rgb0),
        .DE(de0), .HSync_n(hs0), .VSync_n(vs0), .MI(mi0)
    );

    xera4_video_scan #(.V_ACTIVE(16), .V_FP(3), .V_SYNC(4), .V_BP(3), .BASE(15'h7FF0)) u1 (
        .clk(clk), .rst(rst), .Rd_Add(add1), .Rd_In(rd1), .RGB(rgb1),
        .DE(de1), .HSync_n(hs1), .VSync_n(vs1), .MI(mi1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    typedef struct {
        int c;
        int add;
        int de;
        int rgb;
        int hs;
        int vs;
        int mi;
    } vec_t;

    vec_t tv[$];

    int idx, hs_low, hs_first, vs_low, mi_rise, mi_high, de_first, de_last, de1_cnt;
    logic mi_prev, de_prev;

    initial begin
        //                c      add   de  rgb  hs vs mi
        tv.push_back(vec_t'{0,     0,    0, 0,   1, 1, 0});
        tv.push_back(vec_t'{1,     0,    0, 0,   1, 1, 0});
        tv.push_back(vec_t'{2,     1,    1, 0,   1, 1, 0});
        tv.push_back(vec_t'{4,     2,    1, 1,   1, 1, 0});
        tv.push_back(vec_t'{5,     2,    1, 1,   1, 1, 0});
        tv.push_back(vec_t'{6,     3,    1, 2,   1, 1, 0});
        tv.push_back(vec_t'{319,   159,  1, 158, 1, 1, 0});
        tv.push_back(vec_t'{321,   159,  1, 159, 1, 1, 0});
        tv.push_back(vec_t'{322,   159,  0, 0,   1, 1, 0});
        tv.push_back(vec_t'{337,   159,  0, 0,   1, 1, 0});
        tv.push_back(vec_t'{338,   159,  0, 0,   0, 1, 0});
        tv.push_back(vec_t'{369,   159,  0, 0,   0, 1, 0});
        tv.push_back(vec_t'{370,   159,  0, 0,   1, 1, 0});
        tv.push_back(vec_t'{400,   0,    0, 0,   1, 1, 0});
        tv.push_back(vec_t'{402,   1,    1, 0,   1, 1, 0});
        tv.push_back(vec_t'{800,   160,  0, 0,   1, 1, 0});
        tv.push_back(vec_t'{802,   161,  1, 160, 1, 1, 0});
        tv.push_back(vec_t'{1200,  160,  0, 0,   1, 1, 0});
        tv.push_back(vec_t'{6319,  1279, 1, 254, 1, 1, 0});
        tv.push_back(vec_t'{6321,  1279, 1, 255, 1, 1, 0});
        tv.push_back(vec_t'{6322,  1279, 0, 0,   1, 1, 0});
        tv.push_back(vec_t'{6401,  1279, 0, 0,   1, 1, 0});
        tv.push_back(vec_t'{6402,  1279, 0, 0,   1, 1, 1});
        tv.push_back(vec_t'{6801,  1279, 0, 0,   1, 1, 1});
        tv.push_back(vec_t'{6802,  1279, 0, 0,   1, 1, 0});
        tv.push_back(vec_t'{7601,  1279, 0, 0,   1, 1, 0});
        tv.push_back(vec_t'{7602,  1279, 0, 0,   1, 0, 0});
        tv.push_back(vec_t'{9201,  1279, 0, 0,   1, 0, 0});
        tv.push_back(vec_t'{9202,  1279, 0, 0,   1, 1, 0});
        tv.push_back(vec_t'{10399, 1279, 0, 0,   1, 1, 0});
        tv.push_back(vec_t'{10400, 0,    0, 0,   1, 1, 0});
        tv.push_back(vec_t'{10402, 1,    1, 0,   1, 1, 0});

        // Reset state while rst is held.
        #23;
        chk("rst_add",  32'(add0), 0);
        chk("rst_add1", 32'(add1), 32'h7FF0);
        chk("rst_rgb",  32'(rgb0), 0);
        chk("rst_de",   32'(de0),  0);
        chk("rst_hs",   32'(hs0),  1);
        chk("rst_vs",   32'(vs0),  1);
        chk("rst_mi",   32'(mi0),  0);

        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        idx = 0;
        hs_low = 0; hs_first = -1; vs_low = 0; mi_rise = 0; mi_high = 0;
        de_first = -1; de_last = -1; de1_cnt = 0;
        mi_prev = 1'b0; de_prev = 1'b0;

        // One full frame plus the first pixels of the next.
        while (cyc <= 10402) begin
            if (idx < tv.size() && tv[idx].c == cyc) begin
                chk("vec_add", 32'(add0), tv[idx].add);
                chk("vec_de",  32'(de0),  tv[idx].de);
                chk("vec_rgb", 32'(rgb0), tv[idx].rgb);
                chk("vec_hs",  32'(hs0),  tv[idx].hs);
                chk("vec_vs",  32'(vs0),  tv[idx].vs);
                chk("vec_mi",  32'(mi0),  tv[idx].mi);
                idx++;
            end
            if (cyc == 0)  chk("wrap_add_base", 32'(add1), 32'h7FF0);
            if (cyc == 30) chk("wrap_add_7fff", 32'(add1), 32'h7FFF);
            if (cyc == 32) chk("wrap_add_0000", 32'(add1), 0);
            if (cyc == 33) chk("wrap_rgb_ff",   32'(rgb1), 8'hFF);
            if (cyc == 34) chk("wrap_rgb_00",   32'(rgb1), 0);
            if (cyc <= 401 && !hs0) begin
                hs_low++;
                if (hs_first < 0) hs_first = cyc;
            end
            if (cyc <= 401 && de1) de1_cnt++;
            if (!vs0) vs_low++;
            if (mi0) mi_high++;
            if (mi0 && !mi_prev) mi_rise++;
            if (de0 && !de_prev) begin
                if (de_first < 0) de_first = cyc;
                de_last = cyc;
            end
            mi_prev = mi0;
            de_prev = de0;
            step();
        end
        chk("vec_table_done", 32'(idx), 32'(tv.size()));
        chk("hs_first_low", 32'(hs_first), 338);
        chk("hs_width",     32'(hs_low),   32);
        chk("vs_width",     32'(vs_low),   1600);
        chk("mi_rises",     32'(mi_rise),  1);
        chk("mi_width",     32'(mi_high),  400);
        chk("frame_period", 32'(de_last - de_first), 10400);
        chk("wrap_de_cnt",  32'(de1_cnt),  320);

        // Mid-frame reset while MI is high (second frame, vc=16, hc=100).
        while (cyc < 16900) step();
        chk("pre_rst_mi", 32'(mi0), 1);
        rst = 1'b1;
        #1;
        chk("arst_mi",  32'(mi0),  0);
        chk("arst_de",  32'(de0),  0);
        chk("arst_hs",  32'(hs0),  1);
        chk("arst_vs",  32'(vs0),  1);
        chk("arst_add", 32'(add0), 0);
        chk("arst_rgb", 32'(rgb0), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_mi",  32'(mi0),  0);
        chk("held_add", 32'(add0), 0);
        rst = 1'b0;
        cyc = 0;
        mi_high = 0;
        while (cyc <= 6402) begin
            if (cyc == 0) chk("restart_add0", 32'(add0), 0);
            if (cyc == 2) chk("restart_de2",  32'(de0),  1);
            if (cyc == 4) chk("restart_rgb4", 32'(rgb0), 1);
            if (cyc == 6402) chk("restart_mi_rise", 32'(mi0), 1);
            else if (mi0) mi_high++;
            step();
        end
        chk("restart_mi_quiet", 32'(mi_high), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
